// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: stall FSM encodings, register-zero constant
// and the default mul/div front-end latency (also used by the EX-stage mul/div unit).
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MC_STALL   = 2'b01,
        ST_RESET_HOLD = 2'b10
    } stall_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MULDIV_LAT_DFLT = 4;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the sources of the
// instruction in ID. Register zero never produces a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       load_use_o
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit     = (ex_rt_i == id_rs_i);
        rt_hit     = id_uses_rt_i && (ex_rt_i == id_rt_i);
        load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, multi-cycle mul/div stalls and
// wrong-path squash on taken branches. Optional perf counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULDIV_LAT = MULDIV_LAT_DFLT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_BranchTaken,
    input  logic        EX_MulDivStart,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_noOp,
    output logic [1:0]  StallState
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushCount
`endif
);

    localparam int unsigned CNT_W = $clog2(MULDIV_LAT + 1);
    // The start cycle in RUN is the first stall cycle, so MC_STALL covers LAT-1 more.
    localparam logic [CNT_W-1:0] CNT_RELOAD = (MULDIV_LAT > 1) ? CNT_W'(MULDIV_LAT - 2) : '0;

    stall_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    load_use_detect u_load_use_detect (
        .id_rs_i       (ID_rs),
        .id_rt_i       (ID_rt),
        .id_uses_rt_i  (ID_UsesRt),
        .ex_mem_read_i (EX_MemRead),
        .ex_rt_i       (EX_rt),
        .load_use_o    (load_use)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_RESET_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        IF_ID_Flush = 1'b1;
        ID_EX_noOp  = 1'b1;

        case (state_q)
            ST_RUN: begin
                if (EX_BranchTaken) begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                end else if (EX_MulDivStart) begin
                    IF_ID_Flush = 1'b0;
                    if (MULDIV_LAT > 1) begin
                        state_d = ST_MC_STALL;
                        cnt_d   = CNT_RELOAD;
                    end
                end else if (load_use) begin
                    IF_ID_Flush = 1'b0;
                end else begin
                    PCWrite     = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b0;
                    ID_EX_noOp  = 1'b0;
                end
            end
            ST_MC_STALL: begin
                // EX holds a bubble here, so branch/muldiv/load-use inputs are ignored.
                IF_ID_Flush = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // ST_RESET_HOLD and the unused 2'b11 encoding: one bubble, then run.
                state_d = ST_RUN;
            end
        endcase
    end

    assign StallState = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic in_hold;
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    assign in_hold = (state_q != ST_RUN) && (state_q != ST_MC_STALL);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else if (!in_hold) begin
            if (!PCWrite) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (IF_ID_Flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule
